// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the fpu normalise/round stage.
// Holds FSM state enum, field widths, exponent limits and packed constants.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 5;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  function automatic logic [31:0] signed_zero(input logic s);
    return s ? NEG_ZERO : POS_ZERO;
  endfunction

  function automatic logic [31:0] signed_inf(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero count of a 27-bit mantissa.
// Ports: a (27-bit value), cnt (zeros above the first set bit, 27 if a==0).
module fpu_lzc (
  input  logic [26:0] a,
  output logic [4:0]  cnt
);

  // Later (higher) set bits overwrite earlier ones, so the MSB wins.
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (a[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fpu_normalize.sv
// fpu_normalize: post-add normalise and round-to-nearest-even stage.
// Ports: clock, reset (async low), input_rdy/input_ack with in_sign,
// in_exp, in_mant; output_rdy/output_ack with packed result.
// Build option FPU_NORM_LZC_EN: single-cycle normalise via fpu_lzc.
module fpu_normalize
  import fpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              input_rdy,
  output logic              input_ack,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              output_rdy,
  input  logic              output_ack,
  output logic [31:0]       result
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_TOP = (EXP_W+1)'(EXP_MAX);

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [31:0]       result_q, result_d;
  logic              ack_q, ack_d;

  logic [EXP_W:0]    exp_inc;
  logic [MANT_W-1:0] sh_r;

  logic              inc;
  logic [24:0]       top;
  logic [FRAC_W-1:0] rnd_frac;
  logic              rnd_hid;
  logic [EXP_W:0]    rnd_exp;

  assign exp_inc = exp_q + EXP_ONE;
  // Right shift keeps everything shifted out in the sticky bit.
  assign sh_r = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};

`ifdef FPU_NORM_LZC_EN
  logic [4:0]     lzc;
  logic [EXP_W:0] exp_m1;
  logic [4:0]     norm_sh;

  fpu_lzc u_lzc (
    .a   (mant_q[MANT_W-2:0]),
    .cnt (lzc)
  );

  // Shift is capped so the exponent never drops below 1.
  always_comb begin
    exp_m1  = (exp_q == '0) ? '0 : exp_q - EXP_ONE;
    norm_sh = lzc;
    if (exp_m1 < {{(EXP_W-4){1'b0}}, lzc}) norm_sh = exp_m1[4:0];
  end
`endif

  // Round on bits 26:3; top[24] is the carry out of the hidden bit.
  always_comb begin
    inc      = mant_q[2] & (mant_q[3] | mant_q[1] | mant_q[0]);
    top      = {1'b0, mant_q[MANT_W-2:3]} + {24'd0, inc};
    rnd_frac = top[22:0];
    rnd_hid  = top[23];
    rnd_exp  = exp_q;
    if (top[24]) begin
      rnd_frac = top[23:1];
      rnd_hid  = 1'b1;
      rnd_exp  = exp_inc;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ack_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (input_rdy) begin
          sign_d  = in_sign;
          exp_d   = (in_exp == '0) ? EXP_ONE
                                   : {1'b0, in_exp};
          mant_d  = in_mant;
          ack_d   = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          result_d = signed_zero(sign_q);
          state_d  = DONE;
        end else if (mant_q[MANT_W-1]) begin
          mant_d = sh_r;
          exp_d  = exp_inc;
          if (exp_inc >= EXP_TOP) begin
            result_d = signed_inf(sign_q);
            state_d  = DONE;
          end
`ifdef FPU_NORM_LZC_EN
          else begin
            state_d = ROUND;
          end
        end else begin
          mant_d  = mant_q << norm_sh;
          exp_d   = exp_q - {{(EXP_W-4){1'b0}}, norm_sh};
          state_d = ROUND;
        end
`else
        end else if (!mant_q[MANT_W-2] && exp_q > EXP_ONE) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end else begin
          if (!mant_q[MANT_W-2]) exp_d = EXP_ONE;
          state_d = ROUND;
        end
`endif
      end
      ROUND: begin
        if (rnd_exp >= EXP_TOP) begin
          result_d = signed_inf(sign_q);
        end else begin
          result_d = {sign_q,
                      rnd_hid ? rnd_exp[EXP_W-1:0] : '0,
                      rnd_frac};
        end
        state_d = DONE;
      end
      DONE: begin
        if (output_ack) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ack_q    <= ack_d;
    end
  end

  assign input_ack  = ack_q;
  assign output_rdy = (state_q == DONE);
  assign result     = result_q;

endmodule

// File: doc/fpu_normalize.md
Name: fpu_normalize

Overview:
- Post-add normalisation and rounding stage, directly downstream of the fpu add datapath.
- Consumes the raw adder output: sign, biased exponent, and an unnormalised 28-bit mantissa carrying a carry bit plus guard/round/sticky bits.
- Produces a packed IEEE-754 single-precision result using round-to-nearest-even.
- Uses the same rdy/ack handshake as the fpu top on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.
- MANT_W, 28, internal mantissa width (FRAC_W+5).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- input_rdy  input  1  upstream asserts when in_* are valid.
- input_ack  output  1  one-cycle pulse: operands latched.
- in_sign  input  1  result sign.
- in_exp  input  EXP_W  biased exponent of the weight-1 position (bit 26).
- in_mant  input  MANT_W  bit27 carry, bit26 hidden, bits25:3 fraction, bit2 guard, bit1 round, bit0 sticky.
- output_rdy  output  1  result valid; held until acknowledged.
- output_ack  input  1  downstream accepts result.
- result  output  32  packed {sign, exp, frac}.

Behaviour:
- Reset (async, reset==0): state IDLE; input_ack=0, output_rdy=0, result=0; internal registers cleared. Reset mid-operation discards work in progress; no output is produced.
- IDLE:
  - input_rdy==1: latch sign/exp/mant, input_ack=1 for exactly one cycle, go NORM.
  - input_rdy is ignored in every other state; input_ack stays 0 there.
- NORM (priority order, evaluated each cycle):
  - mant==0: result=±0 (sign kept), go DONE.
  - mant[27]==1: mant = mant>>1 with new bit0 = old bit1|old bit0 (sticky-or); exp+1. If exp becomes 255, result=±inf, go DONE. Otherwise stay in NORM.
  - mant[26]==0 and exp>1: mant<<1, exp-1, one bit per cycle.
  - mant[26]==0 and exp<=1: subnormal; internal exp forced to 1; go ROUND.
  - else go ROUND.
- ROUND:
  - lsb=mant[3], g=mant[2], rs=mant[1]|mant[0].
  - Increment at bit3 iff g&(lsb|rs).
  - Carry into bit27: shift right 1, exp+1; exp==255 gives ±inf.
  - Encoded exponent = mant[26] ? exp : 0. A subnormal that rounds up into bit26 therefore becomes exp field 1.
  - Load result, go DONE.
- DONE:
  - output_rdy=1; result stable.
  - output_ack==1 sampled: output_rdy=0 next cycle, go IDLE.
  - New input is accepted no earlier than the cycle after leaving DONE.
- Latency from input_ack to output_rdy: 1 (NORM) + k shift cycles + 1 (ROUND) + 1 (DONE). k = number of single-bit shifts.
- Input with in_exp==0 and nonzero mant is treated as exp 1 (subnormal source).
- Exponent arithmetic uses EXP_W+1 bits internally to detect overflow. Underflow is clamped at exp 1, so it never wraps.

Optional Feature:
- Macro FPU_NORM_LZC_EN.
- Defined: NORM completes in one cycle. A leading-zero count on mant[26:0] gives shift s = min(lzc, exp-1); mant<<s, exp-s are applied in one step, and the carry case still takes a single right shift.
- Latency becomes fixed: NORM=1 cycle, ROUND=1, DONE=1.
- Undefined: the iterative one-bit-per-cycle shifting above is used.
- Results are bit-identical in both builds.

Decomposition:
- Shared package fpu_pkg holds:
  - FSM state enum (IDLE, NORM, ROUND, DONE).
  - EXP_W, FRAC_W, MANT_W, EXP_BIAS=127, EXP_MAX=255.
  - Constants POS_ZERO, NEG_ZERO, POS_INF, NEG_INF.
- One sub-module, fpu_lzc: combinational leading-zero counter, 27-bit input, 5-bit output. Instantiated only under FPU_NORM_LZC_EN.

Test Plan:
- sign0, exp 0x83, mant {2'b11, 0111, zeros}: one right shift, result 0x425C0000; input_ack pulses once.
- exp 0x7F, hidden bit at bit 23 (mant=28'h0800000): 3 shift cycles (1 with LZC), result 0x3E000000.
- exp 0x7F, bits26:3 all ones, g=1, r=s=0: round carry, result 0x40000000. Same with frac 0, g=1: tie to even, result 0x3F800000.
- sign1, mant 0: result 0x80000000. exp 0xFE with mant[27]=1: result 0x7F800000.
- Hold output_ack=0 for 5 cycles: output_rdy and result stay stable, input_rdy is not acked. Then ack: output_rdy drops next cycle.
- Pull reset low during NORM: output_rdy=0 and result=0 immediately. Next operation completes correctly.
